// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg
//   Shared definitions for the note sequencer:
//   - seq_state_t : FSM state encoding (IDLE, FETCH, WAIT, LOAD, PLAY, DONE)
//   - ROM word width and the note/duration field positions
//   - song_rom_word() : the song table contents, indexed by song and entry
package note_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    PLAY  = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  localparam int ROM_WORD_W = 12;
  localparam int FIELD_W    = 6;
  localparam int NOTE_MSB   = 11;
  localparam int NOTE_LSB   = 6;
  localparam int DUR_MSB    = 5;
  localparam int DUR_LSB    = 0;

  // Song table. A duration of 0 marks the end of a song; every entry not
  // listed reads as {0,0}, so unlisted songs end immediately.
  //   song 0 : {20,4} {22,2} {24,1} end
  //   song 1 : every entry i is {i+1, (i mod 4)+1}, no end marker
  //   song 2 : {40,3} end
  //   song 3 : {50,5} {51,6} end
  function automatic logic [ROM_WORD_W-1:0] song_rom_word(input int unsigned song,
                                                         input int unsigned index);
    logic [FIELD_W-1:0] note;
    logic [FIELD_W-1:0] dur;
    note = '0;
    dur  = '0;
    case (song)
      0: begin
        case (index)
          0: begin note = 6'd20; dur = 6'd4; end
          1: begin note = 6'd22; dur = 6'd2; end
          2: begin note = 6'd24; dur = 6'd1; end
          default: ;
        endcase
      end
      1: begin
        note = 6'(index + 1);
        dur  = 6'((index % 4) + 1);
      end
      2: begin
        if (index == 0) begin
          note = 6'd40;
          dur  = 6'd3;
        end
      end
      3: begin
        case (index)
          0: begin note = 6'd50; dur = 6'd5; end
          1: begin note = 6'd51; dur = 6'd6; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return {note, dur};
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if
//   Bundles the sequencer's control inputs and note outputs.
//   master : controller side (drives play, next_song, note_done)
//   slave  : sequencer side (drives note/duration/strobe/status)
interface note_sequencer_if #(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32
);
  localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int IDX_W  = (NOTES_PER_SONG > 1) ? $clog2(NOTES_PER_SONG) : 1;

  logic              play;
  logic              next_song;
  logic              note_done;
  logic [5:0]        note_to_load;
  logic [5:0]        duration_to_load;
  logic              load_new_note;
  logic              song_done;
  logic [SONG_W-1:0] current_song;
  logic [IDX_W-1:0]  note_index;

  modport master (
    output play, next_song, note_done,
    input  note_to_load, duration_to_load, load_new_note, song_done,
           current_song, note_index
  );

  modport slave (
    input  play, next_song, note_done,
    output note_to_load, duration_to_load, load_new_note, song_done,
           current_song, note_index
  );
endinterface

// File: rtl/song_rom.sv
// song_rom
//   Synchronous-read song ROM with one cycle of latency.
//   clk   : clock
//   song  : song index (upper address bits)
//   index : entry index within the song (lower address bits)
//   data  : {note[11:6], duration[5:0]} for the address seen on the last edge
module song_rom
  import note_sequencer_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32,
  localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int IDX_W  = (NOTES_PER_SONG > 1) ? $clog2(NOTES_PER_SONG) : 1
) (
  input  logic                  clk,
  input  logic [SONG_W-1:0]     song,
  input  logic [IDX_W-1:0]      index,
  output logic [ROM_WORD_W-1:0] data
);

  // Registered read: the word appears the cycle after its address.
  always_ff @(posedge clk) begin
    data <= song_rom_word(32'(song), 32'(index));
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
//   Walks through a song in the song ROM, handing one note at a time to a
//   downstream note player and waiting for it to finish.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of note_sequencer_if
//           in  play, next_song, note_done
//           out note_to_load, duration_to_load, load_new_note, song_done,
//               current_song, note_index
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32
) (
  input  logic             clk,
  input  logic             reset,
  note_sequencer_if.slave  bus
);

  localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int IDX_W  = (NOTES_PER_SONG > 1) ? $clog2(NOTES_PER_SONG) : 1;
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NOTES_PER_SONG - 1);

  seq_state_t            state;
  logic [SONG_W-1:0]     current_song;
  logic [IDX_W-1:0]      note_index;
  logic                  armed;
  logic [5:0]            note_q;
  logic [5:0]            dur_q;
  logic                  load_q;
  logic                  done_q;
  logic [ROM_WORD_W-1:0] rom_data;

  // The ROM sees the current address every cycle; the word read during
  // FETCH is the one consumed in WAIT.
  song_rom #(
    .NUM_SONGS      (NUM_SONGS),
    .NOTES_PER_SONG (NOTES_PER_SONG)
  ) u_song_rom (
    .clk   (clk),
    .song  (current_song),
    .index (note_index),
    .data  (rom_data)
  );

  // Sequencer FSM with registered outputs. next_song takes priority over
  // everything else, including a note_done in the same cycle. In PLAY,
  // armed only sets after note_done is seen low, so a done level left over
  // from the previous note cannot advance the sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      current_song <= '0;
      note_index   <= '0;
      armed        <= 1'b0;
      note_q       <= '0;
      dur_q        <= '0;
      load_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (bus.next_song) begin
        current_song <= current_song + 1'b1;
        note_index   <= '0;
        armed        <= 1'b0;
        done_q       <= 1'b0;
        state        <= FETCH;
      end else begin
        case (state)
          IDLE: begin
            if (bus.play) state <= FETCH;
          end
          FETCH: begin
            state <= WAIT;
          end
          WAIT: begin
            note_q <= rom_data[NOTE_MSB:NOTE_LSB];
            dur_q  <= rom_data[DUR_MSB:DUR_LSB];
            if (rom_data[DUR_MSB:DUR_LSB] == '0) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              load_q <= 1'b1;
              state  <= LOAD;
            end
          end
          LOAD: begin
            armed <= 1'b0;
            state <= PLAY;
          end
          PLAY: begin
            if (!armed) begin
              if (!bus.note_done) armed <= 1'b1;
            end else if (bus.note_done) begin
              armed <= 1'b0;
              if (note_index == LAST_INDEX) begin
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                note_index <= note_index + 1'b1;
                state      <= FETCH;
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.note_to_load     = note_q;
  assign bus.duration_to_load = dur_q;
  assign bus.load_new_note    = load_q;
  assign bus.song_done        = done_q;
  assign bus.current_song     = current_song;
  assign bus.note_index       = note_index;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
//   Directed, self-checking bench for note_sequencer. Inputs are driven and
//   outputs sampled 1 ns after each rising edge. Expected values are
//   hand-computed from the song table contents.
module tb_note_sequencer;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  note_sequencer_if bus ();

  note_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the three controller inputs together
  task automatic applyStimulus(input logic play, input logic next_song, input logic note_done);
    bus.play      = play;
    bus.next_song = next_song;
    bus.note_done = note_done;
  endtask

  // Advance n rising edges, landing 1 ns after the last one
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset state
    #2;
    checkOutput("rst_note", 32'(bus.note_to_load), 0);
    checkOutput("rst_dur", 32'(bus.duration_to_load), 0);
    checkOutput("rst_load", 32'(bus.load_new_note), 0);
    checkOutput("rst_done", 32'(bus.song_done), 0);
    checkOutput("rst_song", 32'(bus.current_song), 0);
    checkOutput("rst_index", 32'(bus.note_index), 0);
    wait_cycles(2);
    reset = 1'b1;

    // Held in IDLE while play is low
    wait_cycles(3);
    checkOutput("idle_load", 32'(bus.load_new_note), 0);

    // Song 0 entry 0: play sampled on edge 1, strobe after edge 3.
    // note_done is left high across the load to model a stale done level.
    applyStimulus(1'b1, 1'b0, 1'b1);
    wait_cycles(2);
    checkOutput("lat_early", 32'(bus.load_new_note), 0);
    wait_cycles(1);
    checkOutput("lat_load", 32'(bus.load_new_note), 1);
    checkOutput("s0e0_note", 32'(bus.note_to_load), 20);
    checkOutput("s0e0_dur", 32'(bus.duration_to_load), 4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_cycles(1);
    checkOutput("load_one_cycle", 32'(bus.load_new_note), 0);

    // Stale high must not advance; play low is ignored in PLAY
    wait_cycles(3);
    checkOutput("stale_index", 32'(bus.note_index), 0);
    checkOutput("hold_note", 32'(bus.note_to_load), 20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_cycles(1);
    checkOutput("adv_index", 32'(bus.note_index), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    checkOutput("s0e1_load", 32'(bus.load_new_note), 1);
    checkOutput("s0e1_note", 32'(bus.note_to_load), 22);
    checkOutput("s0e1_dur", 32'(bus.duration_to_load), 2);

    // Entry 2, then entry 3 is the end marker
    wait_cycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_cycles(1);
    checkOutput("adv_index2", 32'(bus.note_index), 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    checkOutput("s0e2_note", 32'(bus.note_to_load), 24);
    checkOutput("s0e2_dur", 32'(bus.duration_to_load), 1);
    wait_cycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    checkOutput("end_done", 32'(bus.song_done), 1);
    checkOutput("end_noload", 32'(bus.load_new_note), 0);
    checkOutput("end_index", 32'(bus.note_index), 3);
    wait_cycles(5);
    checkOutput("done_hold", 32'(bus.song_done), 1);
    checkOutput("done_hold_load", 32'(bus.load_new_note), 0);

    // next_song out of DONE: song 1 has 32 nonzero entries
    applyStimulus(1'b0, 1'b1, 1'b0);
    wait_cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ns_song", 32'(bus.current_song), 1);
    checkOutput("ns_index", 32'(bus.note_index), 0);
    checkOutput("ns_done", 32'(bus.song_done), 0);
    wait_cycles(2);
    for (int i = 0; i < 32; i++) begin
      checkOutput("s1_load", 32'(bus.load_new_note), 1);
      checkOutput("s1_note", 32'(bus.note_to_load), 32'(i + 1));
      checkOutput("s1_dur", 32'(bus.duration_to_load), 32'((i % 4) + 1));
      checkOutput("s1_index", 32'(bus.note_index), 32'(i));
      wait_cycles(2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      wait_cycles(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (i < 31) wait_cycles(2);
    end
    checkOutput("s1_done", 32'(bus.song_done), 1);
    checkOutput("s1_last_index", 32'(bus.note_index), 31);
    wait_cycles(3);
    checkOutput("s1_index_stays", 32'(bus.note_index), 31);
    checkOutput("s1_no_load", 32'(bus.load_new_note), 0);

    // Song 2, then next_song during PLAY to song 3
    applyStimulus(1'b0, 1'b1, 1'b0);
    wait_cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    checkOutput("s2_song", 32'(bus.current_song), 2);
    checkOutput("s2_note", 32'(bus.note_to_load), 40);
    checkOutput("s2_dur", 32'(bus.duration_to_load), 3);
    wait_cycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    wait_cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    checkOutput("s3_song", 32'(bus.current_song), 3);
    checkOutput("s3_note", 32'(bus.note_to_load), 50);
    checkOutput("s3_dur", 32'(bus.duration_to_load), 5);

    // Armed note_done together with next_song: next_song wins and wraps
    wait_cycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    wait_cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("wrap_song", 32'(bus.current_song), 0);
    checkOutput("wrap_index", 32'(bus.note_index), 0);
    wait_cycles(2);
    checkOutput("wrap_load", 32'(bus.load_new_note), 1);
    checkOutput("wrap_note", 32'(bus.note_to_load), 20);
    checkOutput("wrap_dur", 32'(bus.duration_to_load), 4);

    // Advance to entry 1, then reset mid-note
    wait_cycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_cycles(3);
    checkOutput("pre_rst_index", 32'(bus.note_index), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_note", 32'(bus.note_to_load), 0);
    checkOutput("arst_dur", 32'(bus.duration_to_load), 0);
    checkOutput("arst_load", 32'(bus.load_new_note), 0);
    checkOutput("arst_done", 32'(bus.song_done), 0);
    checkOutput("arst_song", 32'(bus.current_song), 0);
    checkOutput("arst_index", 32'(bus.note_index), 0);
    wait_cycles(2);
    reset = 1'b1;

    // With play low, toggling note_done must not wake the sequencer
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'(i % 2));
      wait_cycles(1);
      checkOutput("post_rst_idle", 32'(bus.load_new_note), 0);
    end
    checkOutput("post_rst_note", 32'(bus.note_to_load), 0);
    checkOutput("post_rst_index", 32'(bus.note_index), 0);

    // play after release restarts from song 0 entry 0
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_cycles(3);
    checkOutput("restart_load", 32'(bus.load_new_note), 1);
    checkOutput("restart_note", 32'(bus.note_to_load), 20);
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_SONGS, default 4, meaning the number of songs in the song ROM (a power of 2).
REQ-002 The block SHALL have parameter NOTES_PER_SONG, default 32, meaning the ROM entries per song (a power of 2).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port play, input, 1 bit: high means run, low means hold in IDLE.
REQ-006 The block SHALL have port next_song, input, 1 bit: a one-cycle pulse that advances to the next song.
REQ-007 The block SHALL have port note_done, input, 1 bit: the done level from the downstream note player.
REQ-008 The block SHALL have port note_to_load, output, 6 bits: the note code of the current entry.
REQ-009 The block SHALL have port duration_to_load, output, 6 bits: the duration in beats of the current entry.
REQ-010 The block SHALL have port load_new_note, output, 1 bit: a one-cycle strobe meaning the note and duration outputs are new.
REQ-011 The block SHALL have port song_done, output, 1 bit: high while in the DONE state.
REQ-012 The block SHALL have port current_song, output, log2(NUM_SONGS) bits: the active song index.
REQ-013 The block SHALL have port note_index, output, log2(NOTES_PER_SONG) bits: the active entry index.

Function
REQ-014 The FSM states SHALL be IDLE, FETCH, WAIT, LOAD, PLAY and DONE.
REQ-015 IDLE->FETCH SHALL occur when play is sampled high; otherwise the FSM stays in IDLE.
REQ-016 In FETCH, the ROM address {current_song, note_index} SHALL be presented, and the next state SHALL be WAIT.
REQ-017 The song ROM SHALL have 1-cycle read latency; in WAIT the ROM word {note[11:6], duration[5:0]} SHALL be registered onto note_to_load and duration_to_load.
REQ-018 In WAIT, a ROM duration of 0 SHALL be an end-of-song marker giving the transition WAIT->DONE; any other duration SHALL give WAIT->LOAD.
REQ-019 In LOAD, load_new_note SHALL be high for exactly one cycle, and the next state SHALL be PLAY.
REQ-020 The latency from play first sampled high in IDLE to load_new_note high SHALL be exactly 3 cycles.
REQ-021 In PLAY, an internal armed flag SHALL clear on entry and set once note_done is sampled low.
REQ-022 In PLAY, note_done high while armed SHALL increment note_index and transition to FETCH.
REQ-023 A stale note_done held high from the previous note SHALL never advance the FSM.
REQ-024 In PLAY, the level of play SHALL be ignored, since the note player pauses itself.
REQ-025 If note_done completes the entry with note_index = NOTES_PER_SONG-1, the FSM SHALL go to DONE, not wrap to 0.
REQ-026 DONE SHALL hold until next_song or reset, with song_done = 1.
REQ-027 next_song in any state SHALL, in all cases:
- set current_song to (current_song+1) mod NUM_SONGS;
- set note_index to 0;
- clear armed;
- make the next state FETCH.
REQ-028 next_song SHALL override a simultaneous note_done.
REQ-029 When current_song = NUM_SONGS-1, next_song SHALL wrap current_song to 0.
REQ-030 note_to_load and duration_to_load SHALL change only in WAIT and otherwise hold their last value.
REQ-031 load_new_note SHALL be high only in LOAD.

Reset
REQ-032 Asserting reset low SHALL immediately, without waiting for clk, put:
- the state in IDLE;
- current_song and note_index at 0;
- armed at 0;
- note_to_load, duration_to_load, load_new_note and song_done at 0.
REQ-033 Reset asserted mid-note SHALL abandon the note; no load_new_note SHALL be issued until play is sampled high after release.

Structure
REQ-034 The state encoding, ROM word width (12) and field positions SHALL live in a shared package.
REQ-035 The song ROM SHALL be a separate sub-module, song_rom: a synchronous read, 1-cycle latency ROM addressed by {song, index}.

Verification
REQ-036 Scenario: release reset, play=1, song 0 entry 0 = {note 20, dur 4} -> load_new_note high 3 cycles after play is sampled high, note_to_load=20, duration_to_load=4.
REQ-037 Scenario: note_done held high across a load, then low for 2 cycles, then high -> exactly one advance, note_index 0->1, with no advance on the stale high.
REQ-038 Scenario: song 0 entry 3 has duration 0 -> song_done=1 after entry 2 completes, with no load_new_note for entry 3.
REQ-039 Scenario: 32 nonzero entries -> DONE after entry 31, note_index stays 31, song_done=1.
REQ-040 Scenario: next_song in the same cycle as armed note_done with current_song=3 -> current_song=0, note_index=0, and the next load_new_note carries song 0 entry 0.
REQ-041 Scenario: reset pulsed low while in PLAY -> all outputs 0 asynchronously; with play=0 after release, the FSM remains IDLE indefinitely.
